seven_seg_scan_reader: RTL and testbench



---
 rtl/seven_seg_scan_reader.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_seven_seg_scan_reader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_reader.sv
// seven_seg_scan_reader
// Samples a multiplexed, active-low seven-segment bus, turns every settled
// digit strobe back into a BCD code and assembles a multi-digit frame.
// A frame is published only after MATCH_FRAMES identical complete scans.
module seven_seg_scan_reader #(
  parameter int NUM_DIGITS     = 4,
  parameter int SETTLE_CYCLES  = 4,
  parameter int MATCH_FRAMES   = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid,
  output logic                    timeout
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int MCH_W = $clog2(MATCH_FRAMES + 1);
  localparam int IDL_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SET_W-1:0]        SETTLE_MAX = SET_W'(SETTLE_CYCLES);
  localparam logic [MCH_W-1:0]        MATCH_MAX  = MCH_W'(MATCH_FRAMES);
  localparam logic [IDL_W-1:0]        IDLE_MAX   = IDL_W'(TIMEOUT_CYCLES);
  localparam logic [NUM_DIGITS-1:0]   ALL_SET    = {NUM_DIGITS{1'b1}};
  localparam logic [NUM_DIGITS-1:0]   NONE_SET   = {NUM_DIGITS{1'b0}};
  localparam logic [4*NUM_DIGITS-1:0] BLANK_BCD  = {NUM_DIGITS{4'hF}};

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // Segment pattern {g..a} to {err, code}; blank is legal and reads as F.
  function automatic logic [4:0] decode_seg(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'b1000000: res = {1'b0, 4'h0};
      7'b1111001: res = {1'b0, 4'h1};
      7'b0100100: res = {1'b0, 4'h2};
      7'b0110000: res = {1'b0, 4'h3};
      7'b0011001: res = {1'b0, 4'h4};
      7'b0010010: res = {1'b0, 4'h5};
      7'b0000010: res = {1'b0, 4'h6};
      7'b1111000: res = {1'b0, 4'h7};
      7'b0000000: res = {1'b0, 4'h8};
      7'b0010000: res = {1'b0, 4'h9};
      7'b1111111: res = {1'b0, 4'hF};
      default:    res = {1'b1, 4'hE};
    endcase
    return res;
  endfunction

  // A strobe is legal only when exactly one anode line is low.
  function automatic logic strobe_legal(input logic [NUM_DIGITS-1:0] an);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      multi = multi | (seen & ~an[i]);
      seen  = seen | ~an[i];
    end
    return seen & ~multi;
  endfunction

  logic [6:0]              seg_s1_r, seg_s2_r, trk_seg_r;
  logic [NUM_DIGITS-1:0]   an_s1_r, an_s2_r, trk_an_r;
  state_t                  state_r, fsm_nxt_s, start_state_s, state_nxt_s;
  logic [SET_W-1:0]        settle_cnt_r, settle_nxt_s;
  logic [6:0]              trk_seg_nxt_s;
  logic [NUM_DIGITS-1:0]   trk_an_nxt_s;
  logic                    legal_s, same_s, start_capture_s, capture_s;
  logic [4:0]              dec_s;
  logic [NUM_DIGITS-1:0]   mask_r, mask_nxt_s;
  logic [4*NUM_DIGITS-1:0] slot_bcd_r, slot_bcd_nxt_s, last_bcd_r;
  logic [NUM_DIGITS-1:0]   slot_err_r, slot_err_nxt_s, last_err_r;
  logic                    last_valid_r, frame_done_s, frame_eq_s;
  logic [MCH_W-1:0]        match_cnt_r, match_nxt_s;
  logic [IDL_W-1:0]        idle_cnt_r, idle_nxt_s;
  logic                    tmo_fire_s, pend_r, publish_s;

  assign legal_s = strobe_legal(an_s2_r);
  assign dec_s   = decode_seg(seg_s2_r);
  assign same_s  = (an_s2_r == trk_an_r) && (seg_s2_r == trk_seg_r);

  // Two-flop synchronizer for the asynchronous segment and anode lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_r <= 7'h7F;
      seg_s2_r <= 7'h7F;
      an_s1_r  <= ALL_SET;
      an_s2_r  <= ALL_SET;
    end else begin
      seg_s1_r <= seg_in;
      seg_s2_r <= seg_s1_r;
      an_s1_r  <= an_in;
      an_s2_r  <= an_s1_r;
    end
  end

  // Outcome of evaluating the current strobe as a fresh start (WAIT behaviour).
  always_comb begin
    if (legal_s && (SETTLE_CYCLES == 1)) begin
      start_state_s   = ST_HOLD;
      start_capture_s = 1'b1;
    end else if (legal_s) begin
      start_state_s   = ST_SETTLE;
      start_capture_s = 1'b0;
    end else begin
      start_state_s   = ST_WAIT;
      start_capture_s = 1'b0;
    end
  end

  // Scan FSM next state: qualify a settled strobe and decide when to capture.
  always_comb begin
    fsm_nxt_s     = state_r;
    trk_an_nxt_s  = trk_an_r;
    trk_seg_nxt_s = trk_seg_r;
    settle_nxt_s  = settle_cnt_r;
    capture_s     = 1'b0;
    case (state_r)
      ST_WAIT: begin
        fsm_nxt_s     = start_state_s;
        capture_s     = start_capture_s;
        trk_an_nxt_s  = an_s2_r;
        trk_seg_nxt_s = seg_s2_r;
        settle_nxt_s  = SET_W'(1);
      end
      ST_SETTLE: begin
        if (same_s) begin
          settle_nxt_s = settle_cnt_r + SET_W'(1);
          if (settle_nxt_s == SETTLE_MAX) begin
            capture_s = 1'b1;
            fsm_nxt_s = ST_HOLD;
          end else begin
            fsm_nxt_s = ST_SETTLE;
          end
        end else begin
          fsm_nxt_s     = start_state_s;
          capture_s     = start_capture_s;
          trk_an_nxt_s  = an_s2_r;
          trk_seg_nxt_s = seg_s2_r;
          settle_nxt_s  = SET_W'(1);
        end
      end
      ST_HOLD: begin
        // A changed strobe is handled as WAIT in this same cycle.
        if (an_s2_r != trk_an_r) begin
          fsm_nxt_s     = start_state_s;
          capture_s     = start_capture_s;
          trk_an_nxt_s  = an_s2_r;
          trk_seg_nxt_s = seg_s2_r;
          settle_nxt_s  = SET_W'(1);
        end else begin
          fsm_nxt_s = ST_HOLD;
        end
      end
      default: begin
        fsm_nxt_s = ST_WAIT;
      end
    endcase
  end

  // A capture resets the idle counter, so a timeout can only fire without one.
  assign tmo_fire_s  = !capture_s && (mask_r != NONE_SET) && (idle_cnt_r != IDLE_MAX) &&
                       ((idle_cnt_r + IDL_W'(1)) == IDLE_MAX);
  assign state_nxt_s = tmo_fire_s ? ST_WAIT : fsm_nxt_s;

  // Frame slot update: write the decoded digit into the strobed slot.
  always_comb begin
    mask_nxt_s     = mask_r;
    slot_bcd_nxt_s = slot_bcd_r;
    slot_err_nxt_s = slot_err_r;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      mask_nxt_s[i]         = mask_r[i] | (capture_s & ~an_s2_r[i]);
      slot_bcd_nxt_s[4*i+:4] = (capture_s & ~an_s2_r[i]) ? dec_s[3:0] : slot_bcd_r[4*i+:4];
      slot_err_nxt_s[i]     = (capture_s & ~an_s2_r[i]) ? dec_s[4] : slot_err_r[i];
    end
  end

  assign frame_done_s = capture_s && (mask_nxt_s == ALL_SET);
  assign frame_eq_s   = last_valid_r &&
                        ({slot_bcd_nxt_s, slot_err_nxt_s} == {last_bcd_r, last_err_r});

  // Match counter: count consecutive identical frames, saturating at MATCH_FRAMES.
  always_comb begin
    if (frame_done_s) begin
      if (frame_eq_s) begin
        match_nxt_s = (match_cnt_r == MATCH_MAX) ? match_cnt_r : match_cnt_r + MCH_W'(1);
      end else begin
        match_nxt_s = MCH_W'(1);
      end
    end else if (tmo_fire_s) begin
      match_nxt_s = {MCH_W{1'b0}};
    end else begin
      match_nxt_s = match_cnt_r;
    end
  end

  // Idle counter: cleared by a capture, otherwise counts up and saturates.
  always_comb begin
    if (capture_s) begin
      idle_nxt_s = {IDL_W{1'b0}};
    end else if (idle_cnt_r == IDLE_MAX) begin
      idle_nxt_s = idle_cnt_r;
    end else begin
      idle_nxt_s = idle_cnt_r + IDL_W'(1);
    end
  end

  assign publish_s = pend_r && (match_cnt_r == MATCH_MAX) &&
                     ({last_bcd_r, last_err_r} != {bcd_out, digit_err});

  // Scan FSM state register and strobe tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_WAIT;
      trk_an_r     <= ALL_SET;
      trk_seg_r    <= 7'h7F;
      settle_cnt_r <= {SET_W{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      trk_an_r     <= trk_an_nxt_s;
      trk_seg_r    <= trk_seg_nxt_s;
      settle_cnt_r <= settle_nxt_s;
    end
  end

  // Frame assembly, last-frame store, match and idle bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_r       <= NONE_SET;
      slot_bcd_r   <= BLANK_BCD;
      slot_err_r   <= NONE_SET;
      last_bcd_r   <= BLANK_BCD;
      last_err_r   <= NONE_SET;
      last_valid_r <= 1'b0;
      match_cnt_r  <= {MCH_W{1'b0}};
      idle_cnt_r   <= {IDL_W{1'b0}};
      pend_r       <= 1'b0;
    end else begin
      slot_bcd_r  <= slot_bcd_nxt_s;
      slot_err_r  <= slot_err_nxt_s;
      match_cnt_r <= match_nxt_s;
      idle_cnt_r  <= idle_nxt_s;
      pend_r      <= frame_done_s;
      if (frame_done_s) begin
        mask_r       <= NONE_SET;
        last_bcd_r   <= slot_bcd_nxt_s;
        last_err_r   <= slot_err_nxt_s;
        last_valid_r <= 1'b1;
      end else if (tmo_fire_s) begin
        mask_r <= NONE_SET;
      end else begin
        mask_r <= mask_nxt_s;
      end
    end
  end

  // Registered outputs: publish a confirmed new frame, pulse on timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_out     <= BLANK_BCD;
      digit_err   <= NONE_SET;
      frame_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      frame_valid <= publish_s;
      timeout     <= tmo_fire_s;
      if (publish_s) begin
        bcd_out   <= last_bcd_r;
        digit_err <= last_err_r;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_reader.sv
// Directed bench for seven_seg_scan_reader: expected frames are queued as the
// publishing scan is driven and popped when frame_valid pulses.
module tb_seven_seg_scan_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_in = 7'h7F;
  logic [3:0]  an_in = 4'hF;
  logic [15:0] bcd_out;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        timeout;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int exp_pulse_cnt = 0;
  int tmo_cnt = 0;
  int exp_tmo_cnt = 0;
  logic [15:0] exp_bcd = 16'hFFFF;
  logic [3:0]  exp_err = 4'h0;
  logic [19:0] exp_q[$];
  logic [19:0] exp_e;

  always #5 clk = ~clk;

  seven_seg_scan_reader #(
    .NUM_DIGITS(4), .SETTLE_CYCLES(4), .MATCH_FRAMES(2), .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in),
    .bcd_out(bcd_out), .digit_err(digit_err),
    .frame_valid(frame_valid), .timeout(timeout)
  );

  // Independent encoder; any code above 9 gives an illegal pattern.
  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0101010;
    endcase
  endfunction

  // Output monitor: every frame_valid pulse must match the queued frame.
  always @(negedge clk) begin
    if (rst_n && timeout) tmo_cnt++;
    if (rst_n && frame_valid) begin
      pulse_cnt++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_pulse got bcd_out=%h digit_err=%b expected no pulse", bcd_out, digit_err);
      end
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        checks++;
        assert (bcd_out === exp_e[19:4]) else begin
          errors++;
          $error("FAIL pulse_bcd got %h expected %h", bcd_out, exp_e[19:4]);
        end
        checks++;
        assert (digit_err === exp_e[3:0]) else begin
          errors++;
          $error("FAIL pulse_err got %b expected %b", digit_err, exp_e[3:0]);
        end
      end
    end
  end

  task automatic expect_frame(input logic [15:0] eb, input logic [3:0] ee);
    exp_q.push_back({eb, ee});
    exp_pulse_cnt++;
    exp_bcd = eb;
    exp_err = ee;
  endtask

  task automatic strobe(input int idx, input logic [6:0] pat, input int n);
    an_in  = ~(4'b0001 << idx);
    seg_in = pat;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    an_in  = 4'hF;
    seg_in = 7'h7F;
    repeat (n) @(negedge clk);
  endtask

  // One scan of digits 0..3; a publishing scan queues its frame just before digit 3.
  task automatic scan(input int a, input int b, input int c, input int d,
                      input bit pub, input logic [15:0] eb, input logic [3:0] ee);
    strobe(0, seg_of(a), 8);
    strobe(1, seg_of(b), 8);
    strobe(2, seg_of(c), 8);
    if (pub) expect_frame(eb, ee);
    strobe(3, seg_of(d), 8);
  endtask

  task automatic checkpoint(input string tag);
    checks++;
    assert (pulse_cnt === exp_pulse_cnt) else begin
      errors++;
      $error("FAIL %s_pulses got %0d expected %0d", tag, pulse_cnt, exp_pulse_cnt);
    end
    checks++;
    assert (exp_q.size() === 0) else begin
      errors++;
      $error("FAIL %s_pending got %0d expected 0", tag, exp_q.size());
    end
    checks++;
    assert (tmo_cnt === exp_tmo_cnt) else begin
      errors++;
      $error("FAIL %s_timeouts got %0d expected %0d", tag, tmo_cnt, exp_tmo_cnt);
    end
    checks++;
    assert (bcd_out === exp_bcd) else begin
      errors++;
      $error("FAIL %s_bcd got %h expected %h", tag, bcd_out, exp_bcd);
    end
    checks++;
    assert (digit_err === exp_err) else begin
      errors++;
      $error("FAIL %s_err got %b expected %b", tag, digit_err, exp_err);
    end
  endtask

  task automatic check_reset(input string tag);
    checks++;
    assert (bcd_out === 16'hFFFF) else begin
      errors++; $error("FAIL %s_bcd got %h expected ffff", tag, bcd_out);
    end
    checks++;
    assert (digit_err === 4'h0) else begin
      errors++; $error("FAIL %s_err got %b expected 0000", tag, digit_err);
    end
    checks++;
    assert (frame_valid === 1'b0) else begin
      errors++; $error("FAIL %s_fv got %b expected 0", tag, frame_valid);
    end
    checks++;
    assert (timeout === 1'b0) else begin
      errors++; $error("FAIL %s_tmo got %b expected 0", tag, timeout);
    end
  endtask

  initial begin
    // Power-on reset.
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    idle(5);
    checkpoint("post_reset");

    // Two identical scans publish once; a third identical scan is silent.
    scan(1, 2, 3, 4, 1'b0, 16'h0, 4'h0);
    scan(1, 2, 3, 4, 1'b1, 16'h4321, 4'h0);
    scan(1, 2, 3, 4, 1'b0, 16'h0, 4'h0);
    idle(10);
    checkpoint("basic");

    // Digit 2 toggles every 3 cycles (never settles), then holds steady.
    strobe(0, seg_of(5), 8);
    strobe(1, seg_of(6), 8);
    for (int k = 0; k < 8; k++) strobe(2, seg_of((k % 2 == 0) ? 7 : 8), 3);
    strobe(2, seg_of(7), 6);
    strobe(3, seg_of(8), 8);
    scan(5, 6, 7, 8, 1'b1, 16'h8765, 4'h0);
    idle(10);
    checkpoint("settle");

    // Illegal pattern on digit 1 reads as E with its error flag.
    scan(1, 14, 3, 4, 1'b0, 16'h0, 4'h0);
    scan(1, 14, 3, 4, 1'b1, 16'h43E1, 4'b0010);
    idle(10);
    checkpoint("bad_digit");

    // 1234 x2, single 1235 glitch, then 1239 x2.
    scan(1, 2, 3, 4, 1'b0, 16'h0, 4'h0);
    scan(1, 2, 3, 4, 1'b1, 16'h4321, 4'h0);
    scan(1, 2, 3, 5, 1'b0, 16'h0, 4'h0);
    idle(10);
    checkpoint("glitch");
    scan(1, 2, 3, 9, 1'b0, 16'h0, 4'h0);
    scan(1, 2, 3, 9, 1'b1, 16'h9321, 4'h0);
    idle(10);
    checkpoint("update");

    // Partial frame then long idle: one timeout, outputs unchanged.
    strobe(0, seg_of(1), 8);
    strobe(1, seg_of(2), 8);
    exp_tmo_cnt++;
    idle(1100);
    checkpoint("timeout");
    scan(5, 6, 7, 8, 1'b0, 16'h0, 4'h0);
    scan(5, 6, 7, 8, 1'b1, 16'h8765, 4'h0);
    idle(10);
    checkpoint("after_timeout");

    // Two anodes low is never captured, so digits 1..3 leave a partial frame.
    an_in  = 4'b1100;
    seg_in = seg_of(9);
    repeat (20) @(negedge clk);
    strobe(1, seg_of(2), 8);
    strobe(2, seg_of(3), 8);
    strobe(3, seg_of(4), 8);
    exp_tmo_cnt++;
    idle(1100);
    checkpoint("double_strobe");

    // Reset mid-scan, then two clean scans publish.
    strobe(0, seg_of(1), 8);
    strobe(1, seg_of(2), 4);
    rst_n = 1'b0;
    #1;
    check_reset("mid_reset");
    exp_bcd = 16'hFFFF;
    exp_err = 4'h0;
    idle(2);
    rst_n = 1'b1;
    idle(3);
    checkpoint("after_mid_reset");
    scan(1, 2, 3, 4, 1'b0, 16'h0, 4'h0);
    scan(1, 2, 3, 4, 1'b1, 16'h4321, 4'h0);
    idle(10);
    checkpoint("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
